// File: rtl/avr_pkg.sv
// Shared definitions for the AVR sequencing controller: PC select codes,
// controller states, instruction classes and opcode match masks.
package avr_pkg;

   // Fetch PC select encodings
   localparam logic [2:0] PC_ZERO = 3'b000;
   localparam logic [2:0] PC_HOLD = 3'b001;
   localparam logic [2:0] PC_INC1 = 3'b010;
   localparam logic [2:0] PC_INC2 = 3'b011;
   localparam logic [2:0] PC_REL  = 3'b100;
   localparam logic [2:0] PC_ABS  = 3'b101;

   typedef enum logic [2:0] {
      ST_BOOT, ST_RUN, ST_WORD2, ST_MEM, ST_SKIP, ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      CL_NONE, CL_ALU, CL_RJMP, CL_BRANCH, CL_JMP, CL_LDST, CL_SBR, CL_HALT
   } iclass_t;

   // Opcode match masks / values (instr & MASK) == VAL
   localparam logic [15:0] MASK_ADDC = 16'hEC00;  // ADD / ADC 000x11
   localparam logic [15:0] VAL_ADDC  = 16'h0C00;
   localparam logic [15:0] MASK_SUB  = 16'hFC00;  // SUB 000110
   localparam logic [15:0] VAL_SUB   = 16'h1800;
   localparam logic [15:0] MASK_NIB  = 16'hF000;  // top-nibble opcodes
   localparam logic [15:0] VAL_SUBI  = 16'h5000;
   localparam logic [15:0] VAL_LDI   = 16'hE000;
   localparam logic [15:0] VAL_RJMP  = 16'hC000;
   localparam logic [15:0] MASK_BR   = 16'hF800;  // BRBS / BRBC
   localparam logic [15:0] VAL_BR    = 16'hF000;
   localparam logic [15:0] MASK_JMP  = 16'hFE0E;  // JMP
   localparam logic [15:0] VAL_JMP   = 16'h940C;
   localparam logic [15:0] MASK_JC   = 16'hFE0C;  // JMP or CALL
   localparam logic [15:0] VAL_JC    = 16'h940C;
   localparam logic [15:0] MASK_LDST = 16'hFC0F;  // LDS / STS
   localparam logic [15:0] VAL_LDST  = 16'h9000;
   localparam logic [15:0] MASK_SBR  = 16'hFC08;  // SBRC / SBRS
   localparam logic [15:0] VAL_SBR   = 16'hFC00;
   localparam logic [15:0] OP_SLEEP  = 16'h9588;
   localparam logic [15:0] OP_BREAK  = 16'h9598;

   function automatic logic op_match(input logic [15:0] instr,
                                     input logic [15:0] mask,
                                     input logic [15:0] val);
      return (instr & mask) == val;
   endfunction

endpackage

// File: rtl/avr_ctrl_decode.sv
// Combinational instruction decode: class, register address, relative
// jump offset and two-word flag (used when skipping an instruction).
module avr_ctrl_decode
   import avr_pkg::*;
(
   input  logic [15:0] instr,
   output iclass_t     iclass,
   output logic [4:0]  rd_addr,
   output logic [15:0] rel_off,
   output logic        two_word
);

   // Classify the instruction word; SLEEP/BREAK checked first
   always_comb begin
      iclass = CL_NONE;
      if (instr == OP_SLEEP || instr == OP_BREAK)
         iclass = CL_HALT;
      else if (op_match(instr, MASK_ADDC, VAL_ADDC) || op_match(instr, MASK_SUB, VAL_SUB) ||
               op_match(instr, MASK_NIB, VAL_SUBI) || op_match(instr, MASK_NIB, VAL_LDI))
         iclass = CL_ALU;
      else if (op_match(instr, MASK_NIB, VAL_RJMP))
         iclass = CL_RJMP;
      else if (op_match(instr, MASK_BR, VAL_BR))
         iclass = CL_BRANCH;
      else if (op_match(instr, MASK_JMP, VAL_JMP))
         iclass = CL_JMP;
      else if (op_match(instr, MASK_LDST, VAL_LDST))
         iclass = CL_LDST;
      else if (op_match(instr, MASK_SBR, VAL_SBR))
         iclass = CL_SBR;
   end

   // Register address, offsets (+1 folds in the PC increment) and length
   always_comb begin
      if (instr[14] && instr[15:12] != 4'hF)
         rd_addr = {1'b1, instr[7:4]};
      else
         rd_addr = instr[8:4];
      if (instr[15:12] == 4'hC)
         rel_off = {{4{instr[11]}}, instr[11:0]} + 16'd1;
      else
         rel_off = {{9{instr[9]}}, instr[9:3]} + 16'd1;
      two_word = op_match(instr, MASK_JC, VAL_JC) || op_match(instr, MASK_LDST, VAL_LDST);
   end

endmodule

// File: rtl/avr_ctrl.sv
// AVR fetch/execute sequencing controller: drives PC select, register
// write-back strobes and a handshaked data-memory port.
module avr_ctrl
   import avr_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] instr,
   input  logic [7:0]  sreg,
   input  logic [7:0]  rd_data,
   input  logic        mem_ack,
   output logic [2:0]  pc_src,
   output logic [15:0] jmp,
   output logic [4:0]  rd_addr,
   output logic        reg_we,
   output logic        wb_sel,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic        halted
);

   state_t      state_reg, state_next;
   logic [4:0]  rd_lat_reg, rd_lat_next;
   logic        we_flag_reg, we_flag_next;
   logic        jmp_flag_reg, jmp_flag_next;
   logic [15:0] mem_addr_reg, mem_addr_next;

   iclass_t     dec_class;
   logic [4:0]  dec_rd_addr;
   logic [15:0] dec_rel_off;
   logic        dec_two_word;

   avr_ctrl_decode u_decode (
      .instr    (instr),
      .iclass   (dec_class),
      .rd_addr  (dec_rd_addr),
      .rel_off  (dec_rel_off),
      .two_word (dec_two_word)
   );

   // State and latched second-word context
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= ST_BOOT;
         rd_lat_reg   <= '0;
         we_flag_reg  <= 1'b0;
         jmp_flag_reg <= 1'b0;
         mem_addr_reg <= '0;
      end else begin
         state_reg    <= state_next;
         rd_lat_reg   <= rd_lat_next;
         we_flag_reg  <= we_flag_next;
         jmp_flag_reg <= jmp_flag_next;
         mem_addr_reg <= mem_addr_next;
      end
   end

   // Next-state and output decode; reset forces all outputs quiet
   always_comb begin
      state_next    = state_reg;
      rd_lat_next   = rd_lat_reg;
      we_flag_next  = we_flag_reg;
      jmp_flag_next = jmp_flag_reg;
      mem_addr_next = mem_addr_reg;
      pc_src        = PC_INC1;
      jmp           = '0;
      rd_addr       = '0;
      reg_we        = 1'b0;
      wb_sel        = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = mem_addr_reg;
      halted        = 1'b0;
      case (state_reg)
         ST_BOOT: begin
            pc_src     = PC_ZERO;
            state_next = ST_RUN;
         end
         ST_RUN: begin
            rd_addr = dec_rd_addr;
            case (dec_class)
               CL_ALU: reg_we = 1'b1;
               CL_RJMP: begin
                  pc_src = PC_REL;
                  jmp    = dec_rel_off;
               end
               CL_BRANCH: begin
                  if (sreg[instr[2:0]] == ~instr[10]) begin
                     pc_src = PC_REL;
                     jmp    = dec_rel_off;
                  end
               end
               CL_JMP: begin
                  jmp_flag_next = 1'b1;
                  state_next    = ST_WORD2;
               end
               CL_LDST: begin
                  jmp_flag_next = 1'b0;
                  rd_lat_next   = dec_rd_addr;
                  we_flag_next  = instr[9];
                  state_next    = ST_WORD2;
               end
               CL_SBR: begin
                  if (rd_data[instr[2:0]] == instr[9])
                     state_next = ST_SKIP;
               end
               CL_HALT: begin
                  pc_src     = PC_HOLD;
                  state_next = ST_HALT;
               end
               default: ;
            endcase
         end
         ST_WORD2: begin
            if (jmp_flag_reg) begin
               pc_src     = PC_ABS;
               jmp        = instr;
               state_next = ST_RUN;
            end else begin
               rd_addr       = rd_lat_reg;
               mem_addr_next = instr;
               state_next    = ST_MEM;
            end
         end
         ST_MEM: begin
            pc_src  = PC_HOLD;
            rd_addr = rd_lat_reg;
            mem_req = 1'b1;
            mem_we  = we_flag_reg;
            if (mem_ack) begin
               reg_we     = ~we_flag_reg;
               wb_sel     = ~we_flag_reg;
               state_next = ST_RUN;
            end
         end
         ST_SKIP: begin
            pc_src     = dec_two_word ? PC_INC2 : PC_INC1;
            state_next = ST_RUN;
         end
         ST_HALT: begin
            pc_src = PC_HOLD;
            halted = 1'b1;
         end
         default: begin
            pc_src     = PC_ZERO;
            state_next = ST_BOOT;
         end
      endcase
      if (RST) begin
         pc_src   = PC_ZERO;
         jmp      = '0;
         rd_addr  = '0;
         reg_we   = 1'b0;
         wb_sel   = 1'b0;
         mem_req  = 1'b0;
         mem_we   = 1'b0;
         mem_addr = '0;
         halted   = 1'b0;
      end
   end

endmodule

// File: tb/tb_avr_ctrl.sv
// Directed testbench for avr_ctrl: single-cycle RUN vectors from a table,
// then hand-written multi-cycle sequences (JMP, LDS, skip, reset, halt).
module tb_avr_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] instr;
   logic [7:0]  sreg;
   logic [7:0]  rd_data;
   logic        mem_ack;
   logic [2:0]  pc_src;
   logic [15:0] jmp;
   logic [4:0]  rd_addr;
   logic        reg_we;
   logic        wb_sel;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic        halted;

   int vecs = 0;
   int miss = 0;

   avr_ctrl dut (
      .CLK      (CLK),
      .RST      (RST),
      .instr    (instr),
      .sreg     (sreg),
      .rd_data  (rd_data),
      .mem_ack  (mem_ack),
      .pc_src   (pc_src),
      .jmp      (jmp),
      .rd_addr  (rd_addr),
      .reg_we   (reg_we),
      .wb_sel   (wb_sel),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .halted   (halted)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] instr;
      logic [7:0]  sreg;
      logic [7:0]  rd_data;
      logic        mem_ack;
      logic [2:0]  pc;
      logic [15:0] jmp;
      logic [4:0]  rd;
      logic        we;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else
         $display("ok   %s: %h", name, act);
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   initial begin
      // instr, sreg, rd_data, ack, pc_src, jmp, rd_addr, reg_we
      tbl[0]  = '{16'hE505, 8'h00, 8'h00, 1'b0, 3'b010, 16'h0000, 5'd16, 1'b1}; // LDI r16,0x55
      tbl[1]  = '{16'h0C12, 8'h00, 8'h00, 1'b0, 3'b010, 16'h0000, 5'd1,  1'b1}; // ADD r1,r2
      tbl[2]  = '{16'h1C12, 8'h00, 8'h00, 1'b0, 3'b010, 16'h0000, 5'd1,  1'b1}; // ADC r1,r2
      tbl[3]  = '{16'h1812, 8'h00, 8'h00, 1'b0, 3'b010, 16'h0000, 5'd1,  1'b1}; // SUB r1,r2
      tbl[4]  = '{16'h5045, 8'h00, 8'h00, 1'b0, 3'b010, 16'h0000, 5'd20, 1'b1}; // SUBI r20,5
      tbl[5]  = '{16'hEFFF, 8'h00, 8'h00, 1'b0, 3'b010, 16'h0000, 5'd31, 1'b1}; // LDI r31,0xFF
      tbl[6]  = '{16'hCFFE, 8'h00, 8'h00, 1'b0, 3'b100, 16'hFFFF, 5'd31, 1'b0}; // RJMP -2
      tbl[7]  = '{16'hC005, 8'h00, 8'h00, 1'b0, 3'b100, 16'h0006, 5'd16, 1'b0}; // RJMP +5
      tbl[8]  = '{16'hF019, 8'h02, 8'h00, 1'b0, 3'b100, 16'h0004, 5'd1,  1'b0}; // BRBS Z,+3 taken
      tbl[9]  = '{16'hF019, 8'h00, 8'h00, 1'b0, 3'b010, 16'h0000, 5'd1,  1'b0}; // BRBS Z,+3 not taken
      tbl[10] = '{16'hF7F8, 8'h00, 8'h00, 1'b0, 3'b100, 16'h0000, 5'd31, 1'b0}; // BRBC C,-1 taken, wraps
      tbl[11] = '{16'hF7F8, 8'h01, 8'h00, 1'b0, 3'b010, 16'h0000, 5'd31, 1'b0}; // BRBC C,-1 not taken
      tbl[12] = '{16'h0000, 8'h00, 8'h00, 1'b0, 3'b010, 16'h0000, 5'd0,  1'b0}; // NOP
      tbl[13] = '{16'h0000, 8'h00, 8'h00, 1'b1, 3'b010, 16'h0000, 5'd0,  1'b0}; // stray mem_ack ignored
      tbl[14] = '{16'h9500, 8'h00, 8'h00, 1'b0, 3'b010, 16'h0000, 5'd16, 1'b0}; // unlisted opcode
      tbl[15] = '{16'hFC32, 8'h00, 8'h04, 1'b0, 3'b010, 16'h0000, 5'd3,  1'b0}; // SBRC r3,2 no skip

      RST = 1'b1; instr = 16'hE505; sreg = 8'h00; rd_data = 8'h00; mem_ack = 1'b0;
      sample();
      chk("reset outputs", {pc_src, jmp, rd_addr, reg_we, mem_req, mem_we, halted, mem_addr},
          {3'b000, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
      next_cycle();
      RST = 1'b0;
      sample();
      chk("boot pc_src/strobes", {pc_src, reg_we, mem_req}, {3'b000, 1'b0, 1'b0});
      next_cycle();

      // Single-cycle RUN vectors
      for (int i = 0; i < 16; i++) begin
         instr = tbl[i].instr; sreg = tbl[i].sreg; rd_data = tbl[i].rd_data; mem_ack = tbl[i].mem_ack;
         sample();
         chk($sformatf("vec%0d instr=%h", i, tbl[i].instr),
             {pc_src, jmp, rd_addr, reg_we, wb_sel, mem_req, halted},
             {tbl[i].pc, tbl[i].jmp, tbl[i].rd, tbl[i].we, 1'b0, 1'b0, 1'b0});
         next_cycle();
      end
      mem_ack = 1'b0; sreg = 8'h00; rd_data = 8'h00;

      // JMP 0x0123
      instr = 16'h940C; sample();
      chk("jmp word1 pc_src", pc_src, 3'b010);
      next_cycle();
      instr = 16'h0123; sample();
      chk("jmp word2 pc_src/jmp", {pc_src, jmp}, {3'b101, 16'h0123});
      next_cycle();
      instr = 16'h0000; sample();
      chk("after jmp back in run", {pc_src, reg_we}, {3'b010, 1'b0});
      next_cycle();

      // LDS r5,0x0200, ack on third MEM cycle
      instr = 16'h9050; sample();
      chk("lds word1", {pc_src, reg_we, mem_req}, {3'b010, 1'b0, 1'b0});
      next_cycle();
      instr = 16'h0200; sample();
      chk("lds word2", {pc_src, mem_req}, {3'b010, 1'b0});
      next_cycle();
      instr = 16'h0000;
      for (int c = 0; c < 3; c++) begin
         mem_ack = (c == 2);
         sample();
         chk($sformatf("lds mem cycle%0d", c),
             {mem_req, mem_we, mem_addr, pc_src, reg_we, wb_sel, rd_addr},
             {1'b1, 1'b0, 16'h0200, 3'b001, (c == 2), (c == 2), 5'd5});
         next_cycle();
      end
      mem_ack = 1'b0; sample();
      chk("lds done run", {pc_src, mem_req, reg_we}, {3'b010, 1'b0, 1'b0});
      next_cycle();

      // STS with mem_ack held high: completes in first MEM cycle, no write-back
      instr = 16'h9270; next_cycle();
      instr = 16'h0400; next_cycle();
      mem_ack = 1'b1; sample();
      chk("sts ack held", {mem_req, mem_we, mem_addr, reg_we}, {1'b1, 1'b1, 16'h0400, 1'b0});
      next_cycle();
      sample();
      chk("sts done run", {mem_req, pc_src}, {1'b0, 3'b010});
      next_cycle();
      mem_ack = 1'b0;

      // SBRC skip over a one-word instruction
      instr = 16'hFC32; rd_data = 8'h00; next_cycle();
      instr = 16'h0C12; sample();
      chk("skip one-word", {pc_src, reg_we}, {3'b010, 1'b0});
      next_cycle();

      // SBRS r1,0 skip over STS, then STS with reset mid-MEM
      instr = 16'hFE10; rd_data = 8'h01; sample();
      chk("sbrs run", {pc_src, reg_we}, {3'b010, 1'b0});
      next_cycle();
      instr = 16'h9270; sample();
      chk("skip two-word", {pc_src, reg_we, mem_req}, {3'b011, 1'b0, 1'b0});
      next_cycle();
      sample();
      chk("sts rd_addr", {pc_src, rd_addr}, {3'b010, 5'd7});
      next_cycle();
      instr = 16'h0300; next_cycle();
      sample();
      chk("sts mem", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 16'h0300});
      RST = 1'b1; #1;
      chk("rst mid-mem", {mem_req, mem_we, reg_we, pc_src}, {1'b0, 1'b0, 1'b0, 3'b000});
      next_cycle();
      RST = 1'b0; instr = 16'h0000; sample();
      chk("boot after abort", {pc_src, mem_req, mem_addr}, {3'b000, 1'b0, 16'h0});
      next_cycle();

      // SLEEP then 10 halted cycles, released only by reset
      instr = 16'h9588; sample();
      chk("sleep run cycle", {reg_we, halted}, {1'b0, 1'b0});
      next_cycle();
      instr = 16'hE505;
      for (int c = 0; c < 10; c++) begin
         sample();
         chk($sformatf("halt cycle%0d", c), {halted, pc_src, reg_we}, {1'b1, 3'b001, 1'b0});
         next_cycle();
      end
      RST = 1'b1; sample();
      chk("rst clears halted", {halted, pc_src}, {1'b0, 3'b000});
      next_cycle();
      RST = 1'b0; sample();
      chk("boot after halt", {pc_src, halted}, {3'b000, 1'b0});
      next_cycle();
      sample();
      chk("run after halt", {pc_src, reg_we, halted}, {3'b010, 1'b1, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
